// File: rtl/lane_gather_pkg.sv
// Shared constants and state encoding for the four-lane byte gatherer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lane_gather_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [0:0] {
        GATHER = 1'b0,
        HOLD   = 1'b1
    } gather_state_e;

endpackage

// File: rtl/lane_capture_reg.sv
// One lane's byte buffer plus its "byte held" flag.
// Latency: a load is visible on buffer/captured the cycle after it is asserted.
// Backpressure: none locally; the parent withholds load by deasserting lane_ready.
module lane_capture_reg
    import lane_gather_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [LANE_W-1:0] data,
    output logic [LANE_W-1:0] buffer,
    output logic              captured
);

    logic [LANE_W-1:0] buffer_q;
    logic              captured_q;

    // Capture the byte on load; clear only drops the flag so the stale byte stays put.
    // Clear beats load: a timeout discards whatever arrived in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer_q   <= '0;
            captured_q <= 1'b0;
        end else begin
            if (load) begin
                buffer_q <= data;
            end
            if (clear) begin
                captured_q <= 1'b0;
            end else if (load) begin
                captured_q <= 1'b1;
            end
        end
    end

    assign buffer   = buffer_q;
    assign captured = captured_q;

endmodule

// File: rtl/lane_gather_ctrl.sv
// Gathers one byte from each of four skewed lanes into a 32-bit word; discards late partial gathers.
// Latency: word valid the cycle after the last byte is captured; at best one word per 2 cycles.
// Backpressure: combined_ready low holds the word and keeps all lane_ready low until accepted.
module lane_gather_ctrl
    import lane_gather_pkg::*;
#(
    parameter int SKEW_TIMEOUT = 16,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    input  logic [3:0]           lane_valid,
    output logic [3:0]           lane_ready,
    input  logic [7:0]           data_lane0,
    input  logic [7:0]           data_lane1,
    input  logic [7:0]           data_lane2,
    input  logic [7:0]           data_lane3,
    output logic                 combined_valid,
    input  logic                 combined_ready,
    output logic [31:0]          combined_data,
    output logic                 skew_error,
    output logic [ERR_CNT_W-1:0] skew_err_count
);

    // Counter holds values up to SKEW_TIMEOUT-1, and SKEW_TIMEOUT never exceeds 255.
    localparam logic [7:0] SKEW_LAST = 8'(SKEW_TIMEOUT - 1);

    gather_state_e state_q, state_d;
    logic [7:0]    skew_q, skew_d;
    logic          skew_error_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [NUM_LANES-1:0] captured;
    logic [NUM_LANES-1:0] new_cap;
    logic [NUM_LANES-1:0] gathered;
    logic [LANE_W-1:0]    lane_dat [NUM_LANES];
    logic [LANE_W-1:0]    buf_dat  [NUM_LANES];
    logic                 in_gather;
    logic                 all_done;
    logic                 timeout;
    logic                 accept;
    logic                 clear_all;

    assign lane_dat[0] = data_lane0;
    assign lane_dat[1] = data_lane1;
    assign lane_dat[2] = data_lane2;
    assign lane_dat[3] = data_lane3;

    assign in_gather = (state_q == GATHER);

    // lane_ready depends only on registered state, so no input reaches an output combinationally.
    assign lane_ready = in_gather ? ~captured : '0;
    assign new_cap    = lane_valid & lane_ready;
    assign gathered   = captured | new_cap;
    assign all_done   = in_gather && (&gathered);
    // A non-zero counter implies a partial gather is in progress.
    assign timeout    = in_gather && (skew_q == SKEW_LAST) && !(&gathered);
    assign accept     = (state_q == HOLD) && combined_ready;
    assign clear_all  = timeout || accept;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_capture_reg u_cap (
            .clk      (clk_100mhz),
            .rst      (rst),
            .load     (new_cap[i]),
            .clear    (clear_all),
            .data     (lane_dat[i]),
            .buffer   (buf_dat[i]),
            .captured (captured[i])
        );
    end

    // Next state and skew counter: count while partial, restart on completion, timeout or idle.
    always_comb begin
        state_d = state_q;
        skew_d  = '0;
        if (in_gather) begin
            if (all_done) begin
                state_d = HOLD;
            end else if (!timeout && (|gathered)) begin
                skew_d = skew_q + 8'd1;
            end
        end else if (combined_ready) begin
            state_d = GATHER;
        end
    end

    // State, counter and error reporting registers.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q      <= GATHER;
            skew_q       <= '0;
            skew_error_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            skew_q       <= skew_d;
            skew_error_q <= timeout;
            if (timeout && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign combined_valid = (state_q == HOLD);
    assign combined_data  = {buf_dat[3], buf_dat[2], buf_dat[1], buf_dat[0]};
    assign skew_error     = skew_error_q;
    assign skew_err_count = err_cnt_q;

endmodule

// File: tb/tb_lane_gather_ctrl.sv
module tb_lane_gather_ctrl;

    localparam int T    = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_100mhz = 1'b0;
    logic          rst;
    logic [3:0]    lane_valid;
    logic [3:0]    lane_ready;
    logic [7:0]    data_lane0, data_lane1, data_lane2, data_lane3;
    logic          combined_valid;
    logic          combined_ready;
    logic [31:0]   combined_data;
    logic          skew_error;
    logic [CW-1:0] skew_err_count;

    always #5 clk_100mhz = ~clk_100mhz;

    lane_gather_ctrl #(.SKEW_TIMEOUT(T), .ERR_CNT_W(CW)) dut (
        .clk_100mhz     (clk_100mhz),
        .rst            (rst),
        .lane_valid     (lane_valid),
        .lane_ready     (lane_ready),
        .data_lane0     (data_lane0),
        .data_lane1     (data_lane1),
        .data_lane2     (data_lane2),
        .data_lane3     (data_lane3),
        .combined_valid (combined_valid),
        .combined_ready (combined_ready),
        .combined_data  (combined_data),
        .skew_error     (skew_error),
        .skew_err_count (skew_err_count)
    );

    // Expected per-cycle observables, produced by the stimulus side.
    typedef struct {
        logic [3:0] lr;
        logic       vld;
        logic       err;
        int         cnt;
        bit         drop;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] word_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    // Reference model: which lanes hold a byte, when the first arrived, whether a word waits.
    bit          m_hold = 0;
    logic [3:0]  m_have = 4'h0;
    logic [7:0]  m_byte [4];
    int          m_first = -1;
    bit          m_err_pend = 0;
    int          m_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs and advance the model across the following clock edge.
    task automatic step(input logic [3:0] lv, input logic [31:0] bytes, input logic cr, input logic r);
        exp_t       e;
        logic [3:0] cap;
        @(posedge clk_100mhz);
        #1;
        lane_valid     = lv;
        data_lane0     = bytes[7:0];
        data_lane1     = bytes[15:8];
        data_lane2     = bytes[23:16];
        data_lane3     = bytes[31:24];
        combined_ready = r ? 1'b0 : cr;
        rst            = r;

        e.lr   = m_hold ? 4'h0 : ~m_have;
        e.vld  = m_hold;
        e.err  = m_err_pend;
        e.cnt  = m_errs;
        e.drop = 0;
        m_err_pend = 0;

        if (r) begin
            e.drop  = m_hold;
            m_hold  = 0;
            m_have  = 4'h0;
            m_first = -1;
            m_errs  = 0;
        end else if (m_hold) begin
            if (cr) begin
                m_hold = 0;
                m_have = 4'h0;
            end
        end else begin
            cap = lv & ~m_have;
            for (int i = 0; i < 4; i++) begin
                if (cap[i]) m_byte[i] = bytes[i*8 +: 8];
            end
            if (cap != 4'h0 && m_first < 0) m_first = cyc;
            m_have = m_have | cap;
            if (m_have == 4'hF) begin
                word_q.push_back({m_byte[3], m_byte[2], m_byte[1], m_byte[0]});
                m_hold  = 1;
                m_first = -1;
            end else if (m_first >= 0 && (cyc - m_first) == T - 1) begin
                m_have     = 4'h0;
                m_first    = -1;
                m_err_pend = 1;
                if (m_errs < CMAX) m_errs++;
            end
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'h0, $urandom(), 1'b1, 1'b0);
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the queued expectations.
    exp_t me;
    always @(negedge clk_100mhz) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check("lane_ready", 32'(lane_ready), 32'(me.lr));
            check("combined_valid", 32'(combined_valid), 32'(me.vld));
            check("skew_error", 32'(skew_error), 32'(me.err));
            check("skew_err_count", 32'(skew_err_count), me.cnt);
            if (me.vld && combined_valid) begin
                if (word_q.size() == 0) begin
                    check("word_available", 32'd0, 32'd1);
                end else begin
                    check("combined_data", combined_data, word_q[0]);
                end
            end
            if (me.vld && (combined_ready || me.drop) && word_q.size() > 0) begin
                void'(word_q.pop_front());
            end
        end
    end

    initial begin
        int unsigned p;
        logic [3:0]  lv;
        rst            = 1'b1;
        lane_valid     = 4'h0;
        combined_ready = 1'b0;
        data_lane0 = 8'h0; data_lane1 = 8'h0; data_lane2 = 8'h0; data_lane3 = 8'h0;
        repeat (3) @(posedge clk_100mhz);

        // Reset state.
        step(4'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk_100mhz);
        #1;
        check("reset_combined_data", combined_data, 32'h0);

        // Aligned.
        step(4'hF, 32'h44332211, 1'b1, 1'b0);
        idle(3);

        // Skewed within window: lanes at 0, 3, 7, 15.
        for (int k = 0; k < 17; k++)
            step({k == 15, k == 7, k == 3, k == 0}, $urandom(), 1'b1, 1'b0);
        idle(2);

        // Timeout with lanes 0-2 only, then an aligned word.
        for (int k = 0; k < 16; k++) step(4'h7, $urandom(), 1'b1, 1'b0);
        idle(1);
        step(4'hF, 32'hA3A2A1A0, 1'b1, 1'b0);
        idle(2);

        // Completion coincides with timeout.
        step(4'h7, $urandom(), 1'b1, 1'b0);
        idle(14);
        step(4'h8, $urandom(), 1'b1, 1'b0);
        idle(2);

        // Backpressure: five refused HOLD cycles, accepted on the sixth.
        step(4'hF, $urandom(), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(4'hF, $urandom(), 1'b0, 1'b0);
        step(4'hF, $urandom(), 1'b1, 1'b0);
        idle(2);

        // Reset mid-gather, then a fresh gather.
        step(4'h3, $urandom(), 1'b1, 1'b0);
        step(4'h0, $urandom(), 1'b1, 1'b1);
        step(4'hF, $urandom(), 1'b1, 1'b0);
        idle(2);

        // Reset while holding a word.
        step(4'hF, $urandom(), 1'b0, 1'b0);
        step(4'h0, $urandom(), 1'b0, 1'b1);
        idle(2);

        // Random traffic with varying lane density, backpressure and rare resets.
        p = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0:       p = 5;
                    1:       p = 30;
                    default: p = 90;
                endcase
            end
            for (int i = 0; i < 4; i++) lv[i] = ($urandom_range(0, 99) < p);
            step(lv, $urandom(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        end
        idle(2);

        // Drive enough consecutive timeouts to reach counter saturation.
        for (int n = 0; n < CMAX + 3; n++) begin
            step(4'h1, $urandom(), 1'b1, 1'b0);
            idle(16);
        end
        idle(4);

        @(negedge clk_100mhz);
        #1;
        check("words_left_unseen", 32'(word_q.size()), 32'd0);
        check("checks_left_unseen", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lane_gather_ctrl.md
# lane_gather_ctrl

Sequencer for the four 8-bit data lanes feeding the 32-bit combined word. It accepts one byte per lane through per-lane valid/ready handshakes, tolerating bounded inter-lane skew. Once all four bytes are held, it presents `{buffer3, buffer2, buffer1, buffer0}` downstream with a valid/ready handshake. Partial gathers that exceed the skew window are discarded and reported.

## Interface
Parameters:
- `SKEW_TIMEOUT`, 16: maximum cycles from the first byte captured to the last; range 2..255.
- `ERR_CNT_W`, 8: width of the saturating skew-error counter.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk_100mhz`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `lane_valid`  in  4  bit i qualifies `data_lane<i>`.
- `lane_ready`  out  4  bit i means lane i's byte is accepted this cycle.
- `data_lane0`..`data_lane3`  in  8 each  lane bytes.
- `combined_valid`  out  1  `combined_data` is valid.
- `combined_ready`  in  1  downstream accepts the word.
- `combined_data`  out  32  `{buffer3, buffer2, buffer1, buffer0}`.
- `skew_error`  out  1  one-cycle pulse when a partial gather is discarded.
- `skew_err_count`  out  `ERR_CNT_W`  saturating count of discards.

## Operation
- States are GATHER and HOLD. Reset enters GATHER.
- Reset values:
  - `captured` = 0 and all buffers = 0.
  - `lane_ready` = 4'b1111 from the first cycle after reset.
  - `combined_valid` = 0 and `combined_data` = 0.
  - `skew_error` = 0 and `skew_err_count` = 0.
  - Skew counter = 0.
- GATHER:
  - `lane_ready[i] = ~captured[i]`.
  - A handshake (`lane_valid[i] & lane_ready[i]`) loads `buffer<i>` and sets `captured[i]`.
  - Any subset of lanes may capture in the same cycle.
  - The skew counter is 0 while `captured` == 0. It increments every cycle after the first capture while the gather is partial.
- Completion: when `captured | new_captures` == 4'b1111, the next state is HOLD.
- Timeout: when the counter equals `SKEW_TIMEOUT-1`, the gather is still incomplete, and this cycle's captures do not complete it:
  - next cycle, `captured` clears and the counter resets to 0;
  - `skew_error` pulses for 1 cycle;
  - `skew_err_count` increments, saturating at all-ones;
  - the state stays GATHER;
  - buffers keep their stale values, which are not observable.
- Completion and timeout in the same cycle: completion wins and no error is raised.
- HOLD:
  - `lane_ready` = 0 and `combined_valid` = 1.
  - `combined_data` stays stable until accepted.
  - When `combined_ready` is high, the next state is GATHER with `captured` = 0 and counter = 0.
- `combined_data` is driven straight from the buffers. Byte order is fixed: lane0 in bits [7:0], lane3 in bits [31:24].
- Reset asserted mid-gather or in HOLD aborts the word immediately. No error is flagged.

## Timing
- Latency: the last byte captured in cycle N gives `combined_valid` = 1 in cycle N+1.
- The word is accepted in the first HOLD cycle with `combined_ready` high. Lanes are ready again the following cycle.
- Maximum throughput is one word per 2 cycles, when all lanes are valid and downstream is always ready.
- `skew_error` is asserted in the cycle after the timeout condition.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Structure
- Package `lane_gather_pkg` holds:
  - `NUM_LANES` = 4 and `LANE_W` = 8;
  - the `gather_state_e` enum {GATHER, HOLD}.
- Sub-module `lane_capture_reg` holds one lane's buffer and `captured` flag. Its inputs are `load` and `clear`, and its outputs are `buffer` and `captured`. It is instantiated 4x.
- Top level contains the FSM, the skew counter, the error counter and the output concatenation.

## Test plan
- **Aligned:** all lanes valid in cycle 0 with bytes 0x11/0x22/0x33/0x44 on lanes 0/1/2/3. Expect `combined_valid` in cycle 1 with `combined_data` = 0x44332211. With `combined_ready` held high, `lane_ready` = 4'b1111 in cycle 2.
- **Skewed within window:** lanes 0..3 valid in cycles 0, 3, 7, 15, `SKEW_TIMEOUT` = 16. Expect the word in cycle 16 and no `skew_error`.
- **Timeout:** only lanes 0-2 valid starting in cycle 0. Expect `skew_error` pulse in cycle 16, `skew_err_count` = 1, `lane_ready` = 4'b1111 again. A following aligned gather of 0xA0..0xA3 outputs 0xA3A2A1A0.
- **Completion coincides with timeout:** lane 3 arrives in cycle 15 after lanes 0-2 arrived in cycle 0. Expect a word and no error.
- **Backpressure:** `combined_ready` low for 5 HOLD cycles. Expect `combined_data` stable, `lane_ready` = 0 despite lane valids, and acceptance in the 6th cycle.
- **Reset mid-gather:** `rst` after 2 lanes captured. Expect all outputs at reset values next cycle, then a fresh 4-lane gather succeeds with no error count.
